// File: rtl/obi_tlul_bridge.sv
// obi_tlul_bridge: OBI master to TL-UL device bridge, MAX_OUT outstanding, in-order OBI responses.
package tlul_pkg;
  parameter int TL_AIW = 8;
  parameter logic [15:0] TL_A_USER_DEFAULT = '0;
  typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
  typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;
  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [31:0]       a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    logic [15:0]       a_user;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic [31:0]       d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module obi_tlul_bridge #(
  parameter int MAX_OUT     = 4,
  parameter int SRC_BASE    = 0,
  parameter int NATIVE_SIZE = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       obi_req_i,
  output logic                       obi_gnt_o,
  input  logic [31:0]                obi_addr_i,
  input  logic                       obi_we_i,
  input  logic [3:0]                 obi_be_i,
  input  logic [31:0]                obi_wdata_i,
  output logic                       obi_rvalid_o,
  output logic [31:0]                obi_rdata_o,
  output logic                       obi_err_o,
  output tlul_pkg::tl_h2d_t          tl_o,
  input  tlul_pkg::tl_d2h_t          tl_i,
  output logic [$clog2(MAX_OUT):0]   outstanding_o,
  output logic                       idle_o,
  output logic                       spurious_o
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam int SW = tlul_pkg::TL_AIW;

  logic [PW-1:0]      wr_ptr, rd_ptr, slot;
  logic [CW-1:0]      count;
  logic [MAX_OUT-1:0] pending, done, serr;
  logic [31:0]        sdata [MAX_OUT];
  logic [SW-1:0]      d_idx;
  logic               a_valid, gnt, hit, fast, retire, onehot, half, full;
  logic [1:0]         size, lo;
  logic               unused_sig;

  assign a_valid = obi_req_i && count < CW'(MAX_OUT);
  assign gnt = a_valid && tl_i.a_ready;
  assign obi_gnt_o = gnt;
  assign d_idx = tl_i.d_source - SW'(SRC_BASE);
  assign slot = d_idx[PW-1:0];
  assign hit = tl_i.d_valid && d_idx < SW'(MAX_OUT) && pending[slot];
  // a response for the head slot bypasses the buffer for 1-cycle latency
  assign fast = hit && slot == rd_ptr;
  assign retire = fast || done[rd_ptr];
  assign outstanding_o = count;
  assign idle_o = count == '0;
  assign unused_sig = ^{obi_addr_i[1:0], tl_i.d_opcode, tl_i.d_size};

  always_comb begin
    onehot = obi_be_i inside {4'h1, 4'h2, 4'h4, 4'h8};
    half = obi_be_i inside {4'h3, 4'hC};
    size = !obi_we_i ? 2'd2 : (NATIVE_SIZE != 0 && onehot) ? 2'd0 : (NATIVE_SIZE != 0 && half) ? 2'd1 : 2'd2;
    lo = size == 2'd0 ? {obi_be_i[3] | obi_be_i[2], obi_be_i[3] | obi_be_i[1]} :
         size == 2'd1 ? {obi_be_i[3], 1'b0} : 2'b00;
    full = size != 2'd2 || obi_be_i == 4'hF;
    tl_o = '0;
    tl_o.a_valid = a_valid;
    tl_o.a_opcode = !obi_we_i ? tlul_pkg::Get : full ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
    tl_o.a_param = 3'b000;
    tl_o.a_size = size;
    tl_o.a_source = SW'(SRC_BASE) + SW'(wr_ptr);
    tl_o.a_address = {obi_addr_i[31:2], lo};
    tl_o.a_mask = obi_we_i ? obi_be_i : 4'hF;
    tl_o.a_data = obi_wdata_i;
    tl_o.a_user = tlul_pkg::TL_A_USER_DEFAULT;
    tl_o.d_ready = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pending <= '0;
      done <= '0;
      serr <= '0;
      obi_rvalid_o <= 1'b0;
      obi_rdata_o <= '0;
      obi_err_o <= 1'b0;
      spurious_o <= 1'b0;
    end else begin
      obi_rvalid_o <= retire;
      if (tl_i.d_valid && !hit) spurious_o <= 1'b1;
      if (hit && !fast) begin
        done[slot] <= 1'b1;
        sdata[slot] <= tl_i.d_data;
        serr[slot] <= tl_i.d_error;
      end
      if (retire) begin
        obi_rdata_o <= fast ? tl_i.d_data : sdata[rd_ptr];
        obi_err_o <= fast ? tl_i.d_error : serr[rd_ptr];
        pending[rd_ptr] <= 1'b0;
        done[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (gnt) begin
        pending[wr_ptr] <= 1'b1;
        done[wr_ptr] <= 1'b0;
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count + CW'(gnt) - CW'(retire);
    end
  end
endmodule

// File: tb/tb_obi_tlul_bridge.sv
// tb_obi_tlul_bridge: scoreboard bench; expected responses queued at grant, checked on OBI rvalid.
module tb_obi_tlul_bridge;
  logic clk = 0, rst = 1;
  logic obi_req = 0, obi_we = 0;
  logic [31:0] obi_addr = 0, obi_wdata = 0;
  logic [3:0] obi_be = 0;
  logic obi_gnt_o, obi_rvalid_o, obi_err_o, idle_o, spurious_o;
  logic [31:0] obi_rdata_o;
  logic [2:0] outstanding_o;
  tlul_pkg::tl_h2d_t tl_o, cap;
  tlul_pkg::tl_d2h_t tl_i;
  int n_chk = 0, n_err = 0;
  logic [32:0] q [$];
  logic [32:0] e;
  logic [7:0] exp_tag = 0;
  logic [7:0] t [6];
  logic [7:0] s;

  obi_tlul_bridge #(.MAX_OUT(4), .SRC_BASE(0), .NATIVE_SIZE(1)) dut (
    .clk_i(clk), .rst_i(rst), .obi_req_i(obi_req), .obi_gnt_o(obi_gnt_o),
    .obi_addr_i(obi_addr), .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .tl_o(tl_o), .tl_i(tl_i), .outstanding_o(outstanding_o), .idle_o(idle_o), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (obi_rvalid_o) begin
    if (q.size() == 0) chk("unexp_rvalid", 1, 0);
    else begin
      e = q.pop_front();
      chk("rdata", obi_rdata_o, e[31:0]);
      chk("rerr", {31'b0, obi_err_o}, {31'b0, e[32]});
    end
  end

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee, output logic [7:0] src);
    bit granted = 0;
    obi_req = 1; obi_addr = addr; obi_we = we; obi_be = be; obi_wdata = wd;
    src = '0;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (obi_gnt_o) begin
        granted = 1;
        src = tl_o.a_source;
        cap = tl_o;
        chk("gnt_room", {31'b0, outstanding_o < 3'd4}, 1);
        chk("a_source", {24'b0, src}, {24'b0, exp_tag});
        exp_tag = (exp_tag + 8'd1) % 8'd4;
        q.push_back({ee, ed});
      end
      @(posedge clk); #1;
    end
    obi_req = 0;
    if (!granted) chk("gnt_timeout", 0, 1);
  endtask

  task automatic respond(input logic [7:0] src, input logic [31:0] d, input logic err);
    tl_i.d_valid = 1; tl_i.d_source = src; tl_i.d_data = d; tl_i.d_error = err;
    @(posedge clk); #1;
    tl_i.d_valid = 0;
  endtask

  initial begin
    logic [3:0] bes [6] = '{4'h4, 4'h5, 4'hC, 4'h7, 4'h1, 4'hF};
    logic [1:0] szs [6] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd2};
    logic [1:0] los [6] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0};
    tl_i = '0;
    tl_i.a_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_rvalid", {31'b0, obi_rvalid_o}, 0);
    chk("rst_rdata", obi_rdata_o, 0);
    chk("rst_err", {31'b0, obi_err_o}, 0);
    chk("rst_outst", {29'b0, outstanding_o}, 0);
    chk("rst_idle", {31'b0, idle_o}, 1);
    chk("rst_spur", {31'b0, spurious_o}, 0);

    issue(32'h100, 0, 4'hF, 0, 32'hDEADBEEF, 0, s);
    chk("rd_opcode", {29'b0, cap.a_opcode}, 32'd4);
    chk("rd_size", {30'b0, cap.a_size}, 2);
    chk("rd_mask", {28'b0, cap.a_mask}, 4'hF);
    chk("rd_addr", cap.a_address, 32'h100);
    chk("busy", {31'b0, idle_o}, 0);
    repeat (2) @(posedge clk);
    #1 respond(s, 32'hDEADBEEF, 0);
    chk("rd_latency", {31'b0, obi_rvalid_o}, 1);
    chk("idle_back", {31'b0, idle_o}, 1);

    for (int i = 0; i < 4; i++) issue(32'h400 + 4 * i, 0, 4'hF, 0, 32'hA0000000 | i, 0, t[i]);
    chk("full_outst", {29'b0, outstanding_o}, 4);
    fork
      issue(32'h500, 0, 4'hF, 0, 32'hA0000004, 0, t[4]);
      begin
        @(negedge clk); chk("full_stall0", {31'b0, obi_gnt_o}, 0);
        @(posedge clk); #1 respond(t[3], 32'hA0000003, 0);
        respond(t[1], 32'hA0000001, 0);
        @(negedge clk); chk("full_stall1", {31'b0, obi_gnt_o}, 0);
        @(posedge clk); #1 respond(t[0], 32'hA0000000, 0);
        respond(t[2], 32'hA0000002, 0);
      end
    join
    respond(t[4], 32'hA0000004, 0);
    repeat (3) @(posedge clk);
    #1 chk("ooo_drain", {29'b0, outstanding_o}, 0);

    for (int i = 0; i < 6; i++) begin
      issue(32'h203, 1, bes[i], 32'h00AB0000, 32'h5000 + i, 0, s);
      chk("wr_size", {30'b0, cap.a_size}, {30'b0, szs[i]});
      chk("wr_addr", cap.a_address, {30'h80, los[i]});
      chk("wr_opcode", {29'b0, cap.a_opcode}, {29'b0, ops[i]});
      chk("wr_mask", {28'b0, cap.a_mask}, {28'b0, bes[i]});
      chk("wr_data", cap.a_data, 32'h00AB0000);
      respond(s, 32'h5000 + i, 0);
    end

    issue(32'h300, 0, 4'hF, 0, 32'h1111, 1, s);
    respond(s, 32'h1111, 1);
    issue(32'h304, 0, 4'hF, 0, 32'h2222, 0, s);
    respond(s, 32'h2222, 0);
    @(posedge clk); #1;

    chk("spur_pre", {31'b0, spurious_o}, 0);
    respond(exp_tag, 32'hBAD, 0);
    chk("spur_set", {31'b0, spurious_o}, 1);
    respond(8'd9, 32'hBAD, 1);
    repeat (3) @(posedge clk);
    #1 chk("spur_held", {31'b0, spurious_o}, 1);
    chk("spur_outst", {29'b0, outstanding_o}, 0);

    issue(32'h600, 0, 4'hF, 0, 32'h1, 0, t[0]);
    issue(32'h604, 0, 4'hF, 0, 32'h2, 0, t[1]);
    chk("pre_rst_outst", {29'b0, outstanding_o}, 2);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    q.delete();
    exp_tag = 0;
    chk("mid_rvalid", {31'b0, obi_rvalid_o}, 0);
    chk("mid_rdata", obi_rdata_o, 0);
    chk("mid_err", {31'b0, obi_err_o}, 0);
    chk("mid_outst", {29'b0, outstanding_o}, 0);
    chk("mid_spur", {31'b0, spurious_o}, 0);
    respond(t[0], 32'h77, 0);
    chk("late_spur", {31'b0, spurious_o}, 1);
    issue(32'h700, 0, 4'hF, 0, 32'hCAFEF00D, 0, s);
    respond(s, 32'hCAFEF00D, 0);
    repeat (2) @(posedge clk);
    #1 chk("final_idle", {31'b0, idle_o}, 1);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
